// File: rtl/ps2_key_cmd_ctrl.sv
// PS/2 scan-code sequencer: tracks E0/F0 prefixes, turns key releases into 4-bit commands and
// queues them in a show-ahead FIFO. Define MAKE_EVENTS_EN to also queue de-duplicated presses.
module ps2_key_cmd_ctrl #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick_i,
    input  logic [7:0] rx_data_i,
    output logic       rx_en_o,
    output logic       cmd_valid_o,
    output logic [4:0] cmd_code_o,
    input  logic       cmd_rd_i,
    output logic       cmd_ovf_o,
    input  logic       ovf_clr_i
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TmoW = 20;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e          state_q, state_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [4:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            ovf_q;

    logic [3:0] code;
    logic       mapped;
    logic       make_ev, brk_ev;
    logic       push;
    logic [4:0] push_data;
    logic       full, empty, pop, push_ok;
    logic [4:0] head;

`ifdef MAKE_EVENTS_EN
    logic [3:0] held_q, held_d;
`endif

    always_comb begin
        code = 4'd0;
        case (rx_data_i)
            8'h2B:   code = 4'd1;
            8'h33:   code = 4'd2;
            8'h2C:   code = 4'd3;
            8'h75:   code = 4'd4;
            8'h74:   code = 4'd5;
            8'h6B:   code = 4'd6;
            8'h72:   code = 4'd7;
            8'h76:   code = 4'd8;
            default: code = 4'd0;
        endcase
    end

    assign mapped = (code != 4'd0);

    // Prefix decoder; only acts on received bytes, otherwise runs the resync timeout.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        make_ev = 1'b0;
        brk_ev  = 1'b0;
        if (rx_done_tick_i) begin
            tmo_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (rx_data_i == 8'hE0)      state_d = StExt;
                    else if (rx_data_i == 8'hF0) state_d = StBrk;
                    else begin
                        state_d = StIdle;
                        make_ev = mapped;
                    end
                end
                StExt: begin
                    if (rx_data_i == 8'hF0)      state_d = StExtBrk;
                    else if (rx_data_i == 8'hE0) state_d = StExt;
                    else begin
                        state_d = StIdle;
                        make_ev = mapped;
                    end
                end
                StBrk: begin
                    if (rx_data_i == 8'hF0)      state_d = StBrk;
                    else if (rx_data_i == 8'hE0) state_d = StExtBrk;
                    else begin
                        state_d = StIdle;
                        brk_ev  = mapped;
                    end
                end
                StExtBrk: begin
                    state_d = StIdle;
                    brk_ev  = mapped;
                end
            endcase
        end else if (state_q != StIdle) begin
            if (tmo_q == TmoLast) begin
                state_d = StIdle;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end
    end

`ifdef MAKE_EVENTS_EN
    // Typematic repeats of the held key are suppressed; its release frees the slot.
    always_comb begin
        held_d    = held_q;
        push      = 1'b0;
        push_data = {1'b0, code};
        if (make_ev && (code != held_q)) begin
            push      = 1'b1;
            push_data = {1'b1, code};
            held_d    = code;
        end
        if (brk_ev) begin
            push = 1'b1;
            if (code == held_q) held_d = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) held_q <= 4'd0;
        else       held_q <= held_d;
    end
`else
    logic unused_make;
    assign unused_make = make_ev;
    assign push        = brk_ev;
    assign push_data   = {1'b0, code};
`endif

    assign full    = (cnt_q == CntW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop     = cmd_rd_i & ~empty;
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            tmo_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push_ok && !pop)      cnt_q <= cnt_q + CntW'(1);
            else if (!push_ok && pop) cnt_q <= cnt_q - CntW'(1);
            if (push && full && !pop) ovf_q <= 1'b1;
            else if (ovf_clr_i)       ovf_q <= 1'b0;
        end
    end

    assign head        = empty ? 5'd0 : mem_q[rd_ptr_q];
    assign rx_en_o     = ~full;
    assign cmd_valid_o = ~empty;
    assign cmd_ovf_o   = ovf_q;

`ifdef MAKE_EVENTS_EN
    assign cmd_code_o = head;
`else
    logic unused_head4;
    assign unused_head4 = head[4];
    assign cmd_code_o   = {1'b0, head[3:0]};
`endif

endmodule
